// File: rtl/mem_access.sv
// Load/store unit between the pipeline MEM stage and a single-outstanding memory bus.
// It aligns addresses, forms byte lanes, waits for the bus ack or a timeout, and returns a shifted read word.
module mem_access #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        ld_valid,
   output logic [2:0]  ld_funct3,
   output logic [31:0] ld_data,
   output logic        misalign_err,
   output logic        bus_err,
   output logic [1:0]  fsm_state
);

   // Handshake: a request is taken in IDLE when req_valid=1 and the access is aligned;
   // stall stays high until the DONE cycle, when the result is presented for one cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW = $clog2(TIMEOUT) + 1;

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic [1:0]    off_q;
   logic [2:0]    f3_q;
   logic          misaligned;
   logic          accept;
   logic          timeout_hit;
   logic [3:0]    be_calc;
   logic [31:0]   wdata_calc;

   assign fsm_state = state;

   // funct3[1:0] selects the width; bit 2 only matters to the load-extension stage.
   always_comb begin
      misaligned = 1'b0;
      be_calc    = 4'b1111;
      wdata_calc = wdata;
      case (funct3[1:0])
         2'b00: begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{wdata[7:0]}};
         end
         2'b01: begin
            misaligned = addr[0];
            be_calc    = 4'b0011 << {addr[1], 1'b0};
            wdata_calc = {2{wdata[15:0]}};
         end
         default: misaligned = (addr[1:0] != 2'b00);
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      stall       = 1'b0;
      accept      = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && !misaligned) begin
               accept    = 1'b1;
               stall     = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            stall = 1'b1;
            // An ack in the timeout cycle still completes the access normally.
            if (mem_ack) begin
               state_nxt = DONE;
            end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_nxt   = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= '0;
         mem_wdata    <= '0;
         ld_valid     <= 1'b0;
         ld_funct3    <= '0;
         ld_data      <= '0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
         wait_cnt     <= '0;
         off_q        <= '0;
         f3_q         <= '0;
      end else begin
         misalign_err <= (state == IDLE) && req_valid && misaligned;
         ld_valid     <= 1'b0;
         bus_err      <= 1'b0;
         if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_calc;
            mem_wdata <= wdata_calc;
            off_q     <= addr[1:0];
            f3_q      <= funct3;
            wait_cnt  <= '0;
         end
         if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (mem_ack) begin
               mem_req <= 1'b0;
               if (!mem_we) begin
                  ld_valid  <= 1'b1;
                  ld_data   <= mem_rdata >> {off_q, 3'b000};
                  ld_funct3 <= f3_q;
               end
            end else if (timeout_hit) begin
               mem_req <= 1'b0;
               bus_err <= 1'b1;
               ld_data <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table of single accesses plus
// hand-written sequences for wait states, timeout, reset-in-flight and ignored inputs.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        ld_valid;
   logic [2:0]  ld_funct3;
   logic [31:0] ld_data;
   logic        misalign_err, bus_err;
   logic [1:0]  fsm_state;

   int n_chk  = 0;
   int n_fail = 0;

   mem_access #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ld_valid(ld_valid), .ld_funct3(ld_funct3), .ld_data(ld_data),
      .misalign_err(misalign_err), .bus_err(bus_err), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        mis;
      logic [3:0]  be;
      logic [31:0] mwdata;
      logic [31:0] ldd;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
      req_valid = 1'b1;
      req_we    = we;
      funct3    = f3;
      addr      = a;
      wdata     = wd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] last_ld;
      int          n_wait;
      int          stall_cnt;
      int          ldv_seen;

      vecs[0]  = '{1'b1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0,          1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
      vecs[1]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,          1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0};
      vecs[2]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,          32'hBEEF_1234, 1'b0, 4'b1100, 32'h0,          32'h0000_BEEF};
      vecs[3]  = '{1'b0, 3'b010, 32'h0000_3001, 32'h0,          32'h0,          1'b1, 4'b0000, 32'h0,          32'h0};
      vecs[4]  = '{1'b1, 3'b001, 32'h0000_5002, 32'h0000_CAFE, 32'h0,          1'b0, 4'b1100, 32'hCAFE_CAFE, 32'h0};
      vecs[5]  = '{1'b0, 3'b000, 32'h0000_6001, 32'h1234_5678, 32'h1122_3344, 1'b0, 4'b0010, 32'h7878_7878, 32'h0011_2233};
      vecs[6]  = '{1'b0, 3'b001, 32'h0000_7001, 32'h0,          32'h0,          1'b1, 4'b0000, 32'h0,          32'h0};
      vecs[7]  = '{1'b1, 3'b000, 32'h0000_A000, 32'hFFFF_FF5A, 32'h0,          1'b0, 4'b0001, 32'h5A5A_5A5A, 32'h0};
      vecs[8]  = '{1'b0, 3'b010, 32'h0000_8000, 32'h0,          32'hA5A5_F00F, 1'b0, 4'b1111, 32'h0,          32'hA5A5_F00F};
      vecs[9]  = '{1'b0, 3'b100, 32'h0000_9003, 32'h0,          32'h80FF_EE11, 1'b0, 4'b1000, 32'h0,          32'h0000_0080};
      vecs[10] = '{1'b1, 3'b010, 32'h0000_B002, 32'h1,          32'h0,          1'b1, 4'b0000, 32'h0,          32'h0};

      // Clock/reset
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
      addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) next_cycle();
      chk("rst_state", 32'(fsm_state), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_ld_funct3", 32'(ld_funct3), 32'd0);
      chk("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_stall_idle", 32'(stall), 32'd0);
      last_ld = 32'h0;

      // Vector table: one access each, immediate ack for aligned ones
      for (int i = 0; i < 11; i++) begin
         next_cycle();
         request(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
         #1;
         chk($sformatf("v%0d_stall_req", i), 32'(stall), 32'(!vecs[i].mis));
         next_cycle();
         req_valid = 1'b0;
         #1;
         if (vecs[i].mis) begin
            chk($sformatf("v%0d_misalign", i), 32'(misalign_err), 32'd1);
            chk($sformatf("v%0d_no_req", i), 32'(mem_req), 32'd0);
            chk($sformatf("v%0d_stall_mis", i), 32'(stall), 32'd0);
            chk($sformatf("v%0d_state_mis", i), 32'(fsm_state), 32'd0);
            next_cycle();
            chk($sformatf("v%0d_misalign_pulse", i), 32'(misalign_err), 32'd0);
            chk($sformatf("v%0d_no_req2", i), 32'(mem_req), 32'd0);
         end else begin
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'd1);
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].we));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr & 32'hFFFF_FFFC);
            chk($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].be));
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].mwdata);
            chk($sformatf("v%0d_stall_wait", i), 32'(stall), 32'd1);
            mem_ack = 1'b1;
            mem_rdata = vecs[i].rdata;
            next_cycle();
            mem_ack = 1'b0;
            mem_rdata = 32'hFFFF_FFFF;
            #1;
            chk($sformatf("v%0d_state_done", i), 32'(fsm_state), 32'd2);
            chk($sformatf("v%0d_stall_done", i), 32'(stall), 32'd0);
            chk($sformatf("v%0d_mem_req_drop", i), 32'(mem_req), 32'd0);
            chk($sformatf("v%0d_ld_valid", i), 32'(ld_valid), 32'(!vecs[i].we));
            chk($sformatf("v%0d_bus_err", i), 32'(bus_err), 32'd0);
            if (!vecs[i].we) begin
               last_ld = vecs[i].ldd;
               chk($sformatf("v%0d_ld_funct3", i), 32'(ld_funct3), 32'(vecs[i].f3));
            end
            chk($sformatf("v%0d_ld_data", i), ld_data, last_ld);
            next_cycle();
            chk($sformatf("v%0d_idle", i), 32'(fsm_state), 32'd0);
            chk($sformatf("v%0d_ld_valid_pulse", i), 32'(ld_valid), 32'd0);
         end
      end

      // SB with ack on the second WAIT cycle: three stall cycles, no ld_valid
      stall_cnt = 0; ldv_seen = 0;
      next_cycle();
      request(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
      #1; stall_cnt += int'(stall); ldv_seen += int'(ld_valid);
      next_cycle(); req_valid = 1'b0;
      #1; stall_cnt += int'(stall); ldv_seen += int'(ld_valid);
      next_cycle(); mem_ack = 1'b1;
      #1; stall_cnt += int'(stall); ldv_seen += int'(ld_valid);
      chk("sb2_mem_be", 32'(mem_be), 32'b1000);
      chk("sb2_mem_wdata", mem_wdata, 32'hABAB_ABAB);
      next_cycle(); mem_ack = 1'b0;
      #1; stall_cnt += int'(stall); ldv_seen += int'(ld_valid);
      chk("sb2_done", 32'(fsm_state), 32'd2);
      next_cycle();
      #1; stall_cnt += int'(stall); ldv_seen += int'(ld_valid);
      chk("sb2_stall_cycles", 32'(stall_cnt), 32'd3);
      chk("sb2_no_ld_valid", 32'(ldv_seen), 32'd0);

      // LW with no ack: bus error after 16 WAIT cycles
      next_cycle();
      request(1'b0, 3'b010, 32'h0000_4000, 32'h0);
      next_cycle(); req_valid = 1'b0;
      #1;
      n_wait = 0;
      while (fsm_state == 2'd1 && n_wait < 40) begin
         n_wait++;
         next_cycle();
         #1;
      end
      chk("to_wait_cycles", 32'(n_wait), 32'd16);
      chk("to_state_done", 32'(fsm_state), 32'd2);
      chk("to_bus_err", 32'(bus_err), 32'd1);
      chk("to_ld_valid", 32'(ld_valid), 32'd0);
      chk("to_ld_data", ld_data, 32'd0);
      chk("to_mem_req", 32'(mem_req), 32'd0);
      next_cycle();
      chk("to_idle", 32'(fsm_state), 32'd0);
      chk("to_bus_err_pulse", 32'(bus_err), 32'd0);

      // Ack in the 16th WAIT cycle: the ack wins over the timeout
      next_cycle();
      request(1'b0, 3'b010, 32'h0000_4000, 32'h0);
      next_cycle(); req_valid = 1'b0;
      repeat (15) next_cycle();
      mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
      #1;
      chk("race_still_wait", 32'(fsm_state), 32'd1);
      next_cycle(); mem_ack = 1'b0;
      #1;
      chk("race_ld_valid", 32'(ld_valid), 32'd1);
      chk("race_bus_err", 32'(bus_err), 32'd0);
      chk("race_ld_data", ld_data, 32'h1357_9BDF);

      // Reset mid-WAIT, then a late ack
      next_cycle();
      next_cycle();
      request(1'b0, 3'b010, 32'h0000_4000, 32'h0);
      next_cycle(); req_valid = 1'b0;
      next_cycle();
      next_cycle();
      chk("rw_mem_req_before", 32'(mem_req), 32'd1);
      reset = 1'b1;
      #1;
      chk("rw_mem_req_async", 32'(mem_req), 32'd0);
      chk("rw_state_async", 32'(fsm_state), 32'd0);
      chk("rw_mem_addr_async", mem_addr, 32'd0);
      chk("rw_ld_data_async", ld_data, 32'd0);
      next_cycle(); reset = 1'b0;
      next_cycle(); mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
      next_cycle(); mem_ack = 1'b0;
      #1;
      chk("rw_no_ld_valid", 32'(ld_valid), 32'd0);
      chk("rw_idle", 32'(fsm_state), 32'd0);
      chk("rw_no_req", 32'(mem_req), 32'd0);

      // req_valid held through DONE is not taken as a new request
      next_cycle();
      request(1'b0, 3'b000, 32'h0000_0000, 32'h0);
      next_cycle(); mem_ack = 1'b1; mem_rdata = 32'h0000_00C3;
      next_cycle(); mem_ack = 1'b0;
      #1;
      chk("hold_done", 32'(fsm_state), 32'd2);
      chk("hold_stall_done", 32'(stall), 32'd0);
      chk("hold_ld_data", ld_data, 32'h0000_00C3);
      next_cycle(); req_valid = 1'b0;
      #1;
      chk("hold_idle", 32'(fsm_state), 32'd0);
      chk("hold_no_req", 32'(mem_req), 32'd0);

      // Stray ack in IDLE is ignored
      next_cycle(); mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
      next_cycle(); mem_ack = 1'b0;
      #1;
      chk("stray_ld_valid", 32'(ld_valid), 32'd0);
      chk("stray_idle", 32'(fsm_state), 32'd0);
      chk("stray_ld_data", ld_data, 32'h0000_00C3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum WAIT cycles without mem_ack before a bus error.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  the pipeline MEM stage presents a load or store.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  RISC-V width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 stall  output  1  holds the pipeline.
REQ-010 mem_req  output  1  bus request.
REQ-011 mem_we  output  1  bus write enable.
REQ-012 mem_addr  output  32  word-aligned bus address.
REQ-013 mem_be  output  4  bus byte enables.
REQ-014 mem_wdata  output  32  lane-replicated store data.
REQ-015 mem_ack  input  1  bus completion; one-cycle pulse.
REQ-016 mem_rdata  input  32  bus read word; valid when mem_ack = 1.
REQ-017 ld_valid  output  1  one-cycle pulse: ld_data is valid for the downstream load-extension stage.
REQ-018 ld_funct3  output  3  registered funct3, passed to the load-extension stage.
REQ-019 ld_data  output  32  read word shifted right by 8*addr[1:0].
REQ-020 misalign_err  output  1  one-cycle pulse on a misaligned access.
REQ-021 bus_err  output  1  one-cycle pulse on a bus timeout.

Function
REQ-022 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-023 Alignment: a halfword access with addr[0]=1 is misaligned; a word access with addr[1:0]≠00 is misaligned.
REQ-024 IDLE, with req_valid=1 and an aligned access:
- latch req_we, funct3, addr[1:0], mem_addr=addr&~3, mem_be, mem_wdata;
- assert mem_req from the next cycle;
- go to WAIT;
- stall=1 combinationally in this cycle.
REQ-025 IDLE, with req_valid=1 and a misaligned access:
- no bus request;
- misalign_err=1 for the next cycle;
- stall=0, ld_valid=0;
- stay in IDLE.
REQ-026 Byte enables:
- byte: 0001 << addr[1:0];
- half: 0011 << (2*addr[1]);
- word: 1111;
- loads use the same mapping.
REQ-027 mem_wdata:
- byte: {4{wdata[7:0]}};
- half: {2{wdata[15:0]}};
- word: wdata.
REQ-028 WAIT behaviour:
- mem_req=1 and stall=1;
- a cycle counter increments every WAIT cycle.
REQ-029 WAIT, on mem_ack=1:
- mem_req drops the next cycle;
- for a load, register ld_data = mem_rdata >> (8*addr[1:0]) with zero fill;
- go to DONE.
REQ-030 WAIT, when the counter reaches TIMEOUT-1 without mem_ack:
- go to DONE with bus_err=1;
- ld_data=0, ld_valid=0.
REQ-031 If mem_ack arrives in the same cycle as the timeout, mem_ack SHALL win and bus_err SHALL stay 0.
REQ-032 DONE, lasting exactly one cycle:
- stall=0;
- ld_valid=1 for a successful load, 0 for a store or an error;
- next state IDLE.
REQ-033 req_valid seen during DONE SHALL be ignored; it is the request just completed.
REQ-034 mem_ack outside WAIT SHALL be ignored.
REQ-035 Latency: an aligned load with a zero-wait bus, where mem_ack arrives in the first WAIT cycle, SHALL take 3 cycles (IDLE→WAIT→DONE), with ld_valid in cycle 3.
REQ-036 ld_data and ld_funct3 SHALL hold their values until the next completed load.

Reset
REQ-037 Asserting reset SHALL immediately, without waiting for clk:
- set the state to IDLE and clear the counter;
- force mem_req, mem_we, ld_valid, misalign_err and bus_err to 0;
- force mem_be to 0000, and mem_addr, mem_wdata and ld_data to 0;
- force ld_funct3 to 000.
REQ-038 Reset during WAIT SHALL abandon the transaction; a mem_ack arriving after reset is released SHALL be ignored.
REQ-039 While in IDLE with req_valid=0, stall SHALL be 0 out of reset.

Verification
REQ-040 SB, addr=0x1003, wdata=0x000000AB, ack on the 2nd WAIT cycle:
- mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB;
- stall for 3 cycles, ld_valid stays 0.
REQ-041 LHU, addr=0x2002, mem_rdata=0xBEEF1234, immediate ack:
- ld_data=0x0000BEEF, ld_funct3=101;
- ld_valid pulses in cycle 3.
REQ-042 LW, addr=0x3001:
- misalign_err pulses for one cycle, mem_req is never asserted, stall=0.
REQ-043 LW, addr=0x4000, no ack, TIMEOUT=16:
- bus_err pulses after 16 WAIT cycles, ld_valid=0;
- the FSM returns to IDLE.
REQ-044 Reset asserted mid-WAIT, then a late mem_ack:
- mem_req drops asynchronously;
- no ld_valid, and the FSM stays in IDLE.
REQ-045 mem_ack in the same cycle as the counter reaching TIMEOUT-1:
- ld_valid=1, bus_err=0.
